// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the CPU memory-port arbiter.
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_MAX_DATA_STREAK = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    DATA
  } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data requesters, with a bounded data-streak
// counter so a waiting fetch is eventually served.
module mem_arb_grant import mem_bus_pkg::*; #(
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_valid,
  input  logic   d_valid,
  input  logic   accept,
  output owner_t grant
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  logic [SW-1:0] streak;
  logic          fetch_forced;

  assign fetch_forced = if_valid && (streak == SW'(MAX_DATA_STREAK));

  always_comb begin
    grant = NONE;
    if (d_valid && !fetch_forced) begin
      grant = DATA;
    end else if (if_valid) begin
      grant = FETCH;
    end
  end

  // Streak only grows while fetch is actually waiting behind a data grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (accept) begin
      if (grant == DATA && if_valid) begin
        if (streak != SW'(MAX_DATA_STREAK)) begin
          streak <= streak + SW'(1);
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing the memory port between instruction fetch
// and load/store; holds the FSM, request latch and response routing.
module mem_bus_arbiter import mem_bus_pkg::*; #(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req_valid,
  input  logic [ADDR_WIDTH-1:0]   if_req_addr,
  output logic                    if_req_ready,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  input  logic                    d_req_valid,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic                    d_req_we,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
  output logic                    d_req_ready,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_data,
  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_we,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_req_ready,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

  state_t state, state_nx;
  owner_t owner, grant;
  logic   accept;
  logic   rsp_done;

  mem_arb_grant #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_req_valid),
    .d_valid  (d_req_valid),
    .accept   (accept),
    .grant    (grant)
  );

  // A grant implies the matching valid, so ready alone marks the handshake.
  assign if_req_ready  = (state == IDLE) && (grant == FETCH);
  assign d_req_ready   = (state == IDLE) && (grant == DATA);
  assign accept        = if_req_ready || d_req_ready;
  assign mem_req_valid = (state == REQ);
  assign rsp_done      = (state == WAIT) && mem_rsp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)        state_nx = REQ;
      REQ:     if (mem_req_ready) state_nx = WAIT;
      WAIT:    if (mem_rsp_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Fetches never write, so their we/wstrb/wdata are forced to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner         <= NONE;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else if (accept) begin
      owner <= grant;
      if (grant == DATA) begin
        mem_req_addr  <= d_req_addr;
        mem_req_we    <= d_req_we;
        mem_req_wdata <= d_req_wdata;
        mem_req_wstrb <= d_req_wstrb;
      end else begin
        mem_req_addr  <= if_req_addr;
        mem_req_we    <= 1'b0;
        mem_req_wdata <= '0;
        mem_req_wstrb <= '0;
      end
    end else if (rsp_done) begin
      owner <= NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      if (rsp_done) begin
        if (owner == FETCH) begin
          if_rsp_valid <= 1'b1;
          if_rsp_data  <= mem_rsp_data;
        end else if (owner == DATA) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= mem_rsp_data;
        end
      end
    end
  end

endmodule
